// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: operand width, ALU opcode
// encodings, controller FSM states and a grant-index width helper.
package alu_share_ctrl_pkg;

  localparam int REG_LEN = 32;
  localparam int ALU_OPW = 4;

  // ALU opcodes, RISC-V funct7[5]/funct3 style encoding
  localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OPW-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_OPW-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_OPW-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_OPW-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OPW-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_OPW-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OPW-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_OPW-1:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Grant index width; a single-bit index is kept even for one requester.
  function automatic int grant_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping to the lowest index. Reusable by any shared resource.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] grant,
  output logic          any_req
);

  logic          found_hi;
  logic          found_lo;
  logic [GW-1:0] grant_hi;
  logic [GW-1:0] grant_lo;

  // Two upward scans: one restricted to indices >= ptr, one over everything.
  // The restricted hit has priority; otherwise the wrapped lowest hit wins.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found_hi && (i >= int'(ptr))) begin
        found_hi = 1'b1;
        grant_hi = GW'(i);
      end
      if (req[i] && !found_lo) begin
        found_lo = 1'b1;
        grant_lo = GW'(i);
      end
    end
  end

  assign grant   = found_hi ? grant_hi : grant_lo;
  assign any_req = found_lo;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// registered ALU operands, captured result returned over a per-requester response.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = REG_LEN,
  parameter int OPW     = ALU_OPW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_in1,
  input  logic [NUM_REQ*XLEN-1:0] req_in2,
  input  logic [NUM_REQ*OPW-1:0]  req_op,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_data,
  output logic [XLEN-1:0]         alu_in1,
  output logic [XLEN-1:0]         alu_in2,
  output logic [OPW-1:0]          alu_op,
  input  logic [XLEN-1:0]         alu_out,
  output logic                    busy,
  output state_e                  dbg_state
);

  localparam int GW = grant_width(NUM_REQ);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high for the same requester bit. Requests: req_ready is offered
  // only in IDLE and only to the arbiter's pick. Responses: rsp_valid stays
  // high with stable rsp_data until the owner's rsp_ready is seen high.

  state_e             state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      owner_q, owner_d;
  logic [XLEN-1:0]    alu_in1_q, alu_in1_d;
  logic [XLEN-1:0]    alu_in2_q, alu_in2_d;
  logic [OPW-1:0]     alu_op_q, alu_op_d;
  logic [XLEN-1:0]    rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [GW-1:0]      arb_grant;
  logic               arb_any;

  rr_arbiter #(
    .N  (NUM_REQ),
    .GW (GW)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready[arb_grant] = 1'b1;
          alu_in1_d = req_in1[int'(arb_grant)*XLEN +: XLEN];
          alu_in2_d = req_in2[int'(arb_grant)*XLEN +: XLEN];
          alu_op_d  = req_op[int'(arb_grant)*OPW +: OPW];
          owner_d   = arb_grant;
          rr_ptr_d  = (int'(arb_grant) == NUM_REQ - 1) ? '0 : arb_grant + GW'(1);
          state_d   = ST_EXEC;
        end
      end

      // Operands have been on the ALU inputs for a full cycle; capture its output.
      ST_EXEC: begin
        rsp_data_d           = alu_out;
        rsp_valid_d          = '0;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        rsp_valid_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_op_q    <= alu_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_op    = alu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
